fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx_if.sv | 23 ++
 rtl/fifo_uart_tx.sv | 104 ++++++++++
 tb/tb_fifo_uart_tx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// Bundle between an upstream FIFO and the UART transmitter.
// The master side feeds the FIFO flags and data; the slave side is the transmitter.
interface fifo_uart_tx_if #(
  parameter int width = 8
);
  logic             en;
  logic             empty;
  logic [width-1:0] data_out;
  logic             re;
  logic             tx;
  logic             busy;
  logic             frame_done;

  modport master (
    output en, empty, data_out,
    input  re, tx, busy, frame_done
  );

  modport slave (
    input  en, empty, data_out,
    output re, tx, busy, frame_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops one word from an upstream FIFO and sends it as an 8N1-style frame
// (start bit, width data bits LSB first, stop bit), clks_per_bit clocks per bit.
module fifo_uart_tx #(
  parameter int width        = 8,
  parameter int clks_per_bit = 4
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.slave  bus
);
  localparam int bit_w = $clog2(width + 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [bit_w-1:0]   bit_q, bit_d;
  logic [width-1:0]   shift_q, shift_d;
  logic               re_q, re_d;
  logic               tx_q, tx_d;
  logic               frame_done_q, frame_done_d;
  logic               baud_end;

  assign baud_end = (baud_q == 16'(clks_per_bit - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      re_q         <= 1'b0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      re_q         <= re_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    unique case (state_q)
      IDLE: begin
        if (bus.en && !bus.empty) state_d = POP;
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = bus.data_out;
        state_d = START;
      end
      START: begin
        if (baud_end) state_d = DATA;
        else          baud_d  = baud_q + 16'd1;
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == bit_w'(width - 1)) state_d = STOP;
          else                            bit_d   = bit_q + bit_w'(1);
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) state_d = IDLE;
        else          baud_d  = baud_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase

    // Both counters restart from zero whenever a new state is entered.
    if (state_d != state_q) begin
      baud_d = '0;
      bit_d  = '0;
    end

    // Outputs are registered from next-state values so they line up with state_q.
    re_d         = (state_d == POP);
    frame_done_d = (state_d == STOP) && (baud_d == 16'(clks_per_bit - 1));
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.re         = re_q;
  assign bus.tx         = tx_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a queue-based FIFO model; outputs sampled on negedge.
module tb_fifo_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_uart_tx_if #(.width(8)) bus ();

  fifo_uart_tx #(.width(8), .clks_per_bit(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i = expected tx during bit slot i (start..stop)
    string      name;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] fifo_q [$];
  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: a pop seen during the re cycle presents data for the following cycle.
  initial begin
    bus.empty    = 1'b1;
    bus.data_out = '0;
    forever begin
      @(negedge clk);
      if (bus.re === 1'b1 && fifo_q.size() > 0) bus.data_out = fifo_q.pop_front();
      bus.empty = (fifo_q.size() == 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    else             n_pass++;
  endtask

  task automatic wait_re(output int t);
    bit seen = 0;
    t = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.re === 1'b1) begin
        seen = 1;
        t = cyc;
      end
    end
    chk("re_timeout", {31'd0, seen}, 32'd1);
  endtask

  // Entered at the negedge of the POP cycle; leaves at the negedge of the following IDLE cycle.
  task automatic run_frame(input logic [9:0] exp, input string nm, input bit drop_en);
    int bad_tx = 0, bad_busy = 0, bad_fd = 0;
    chk({nm, "_busy_pop"}, {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk({nm, "_re_load"}, {31'd0, bus.re}, 32'd0);
    chk({nm, "_tx_load"}, {31'd0, bus.tx}, 32'd1);
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (drop_en && c == 0) bus.en = 1'b0;
      if (bus.tx !== exp[c/4]) bad_tx++;
      if (bus.busy !== 1'b1) bad_busy++;
      if (bus.frame_done !== (c == 39)) bad_fd++;
    end
    chk({nm, "_tx_bits"}, bad_tx, 0);
    chk({nm, "_busy_frame"}, bad_busy, 0);
    chk({nm, "_frame_done"}, bad_fd, 0);
    @(negedge clk);
    chk({nm, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
    chk({nm, "_tx_after"}, {31'd0, bus.tx}, 32'd1);
  endtask

  initial begin
    int t, t_prev, re_cnt, tx_bad, busy_bad;

    vecs[0] = '{8'hA5, 10'b1_10100101_0, "a5"};
    vecs[1] = '{8'h00, 10'b1_00000000_0, "00"};
    vecs[2] = '{8'hFF, 10'b1_11111111_0, "ff"};
    vecs[3] = '{8'h3C, 10'b1_00111100_0, "3c"};
    vecs[4] = '{8'h81, 10'b1_10000001_0, "81"};

    // Reset state
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, bus.tx}, 32'd1);
    chk("rst_re", {31'd0, bus.re}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);

    // Enabled but empty: nothing may happen
    rst = 1'b1;
    bus.en = 1'b1;
    re_cnt = 0; tx_bad = 0; busy_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.re !== 1'b0) re_cnt++;
      if (bus.tx !== 1'b1) tx_bad++;
      if (bus.busy !== 1'b0) busy_bad++;
    end
    chk("empty_re", re_cnt, 0);
    chk("empty_tx", tx_bad, 0);
    chk("empty_busy", busy_bad, 0);

    // Single frames from the table
    for (int v = 0; v < 5; v++) begin
      fifo_q.push_back(vecs[v].data);
      wait_re(t);
      run_frame(vecs[v].frame, vecs[v].name, 1'b0);
    end

    // Back-to-back 1..16
    for (int k = 1; k <= 16; k++) fifo_q.push_back(8'(k));
    t_prev = -1;
    for (int k = 1; k <= 16; k++) begin
      wait_re(t);
      if (t_prev >= 0) chk($sformatf("b2b_period_%0d", k), t - t_prev, 43);
      t_prev = t;
      run_frame({1'b1, 8'(k), 1'b0}, $sformatf("b2b_%0d", k), 1'b0);
    end
    chk("b2b_empty", {31'd0, bus.empty}, 32'd1);

    // Reset in DATA bit 3 of 8'hFF; the next frame must carry the next word
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h77);
    wait_re(t);
    repeat (18) @(negedge clk);
    chk("abort_in_data", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tx", {31'd0, bus.tx}, 32'd1);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_re", {31'd0, bus.re}, 32'd0);
    rst = 1'b1;
    wait_re(t);
    run_frame(10'b1_01110111_0, "after_abort", 1'b0);

    // en dropped during START: frame completes, no further pop until en returns
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'h81);
    wait_re(t);
    run_frame(10'b1_01011010_0, "en_drop", 1'b1);
    re_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.re !== 1'b0) re_cnt++;
    end
    chk("en_off_no_re", re_cnt, 0);
    bus.en = 1'b1;
    @(negedge clk);
    chk("en_resume_re", {31'd0, bus.re}, 32'd1);
    run_frame(10'b1_10000001_0, "en_resume", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
